// File: rtl/tick_pkg.sv
// tick_pkg: shared types and constants for the tick scheduler.
// Register map, CTRL field layout and CTRL reset value.
package tick_pkg;

    localparam int NCH = 3;

    localparam logic [2:0] A_CTRL0  = 3'd0;
    localparam logic [2:0] A_PER0   = 3'd1;
    localparam logic [2:0] A_CTRL1  = 3'd2;
    localparam logic [2:0] A_PER1   = 3'd3;
    localparam logic [2:0] A_CTRL2  = 3'd4;
    localparam logic [2:0] A_PER2   = 3'd5;
    localparam logic [2:0] A_STATUS = 3'd6;
    localparam logic [2:0] A_RSVD   = 3'd7;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_PER = 1;
    localparam int CTRL_IRQ = 2;

    typedef struct packed {
        logic irq_en;
        logic periodic;
        logic en;
    } ctrl_t;

    localparam ctrl_t CTRL_DEF = 3'b011;

    function automatic logic [2:0] ctrl_addr(input int ch);
        return 3'(2 * ch);
    endfunction

    function automatic logic [2:0] period_addr(input int ch);
        return 3'(2 * ch + 1);
    endfunction

endpackage

// File: rtl/tick_scheduler_if.sv
// tick_scheduler_if: CPU register bus of the tick scheduler.
// Write strobe, address, write data and registered read data.
interface tick_scheduler_if;
    import tick_pkg::*;

    logic        wr_en;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output wr_en, addr, wdata,
        input  rdata
    );

    modport slave (
        input  wr_en, addr, wdata,
        output rdata
    );

endinterface

// File: rtl/tick_channel.sv
// tick_channel: one programmable tick channel counting us strobes.
// Emits a registered tick and toggles level on each expiry.
module tick_channel
    import tick_pkg::*;
#(
    parameter int PERIOD_W = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                us_stb,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    input  logic                restart,
    output logic                tick,
    output logic                expire,
    output logic                level
);

    logic [PERIOD_W-1:0] cnt;
    logic                run;
    logic                last;

    assign run    = en && (period != '0);
    assign last   = (cnt == period - PERIOD_W'(1));
    // a register write in the expiry cycle swallows the expiry
    assign expire = run && us_stb && last && !restart;

    // counter, tick strobe and square-wave level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            tick  <= 1'b0;
            level <= 1'b0;
        end else begin
            tick <= expire;
            if (expire) begin
                level <= ~level;
            end
            if (restart || !run) begin
                cnt <= '0;
            end else if (us_stb) begin
                cnt <= last ? '0 : cnt + PERIOD_W'(1);
            end
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: shared 1 us prescaler feeding three tick channels.
// Owns the register file, sticky STATUS, read data and interrupt.
module tick_scheduler
    import tick_pkg::*;
#(
    parameter int CLK_PER_US = 100,
    parameter int PERIOD_W   = 20,
    parameter int DEF_P0     = 500,
    parameter int DEF_P1     = 2000,
    parameter int DEF_P2     = 1000000
) (
    input  logic            clk,
    input  logic            reset,
    tick_scheduler_if.slave bus,
    output logic [NCH-1:0]  tick_o,
    output logic [NCH-1:0]  level_o,
    output logic            irq_o
);

    localparam int PW = $clog2(CLK_PER_US);

    logic [PW-1:0]       pcnt;
    logic                us_stb;
    ctrl_t               ctrl   [NCH];
    logic [PERIOD_W-1:0] period [NCH];
    logic [NCH-1:0]      status;
    logic [NCH-1:0]      restart;
    logic [NCH-1:0]      expire;
    logic [NCH-1:0]      irq_en;
    logic [NCH-1:0]      clr;
    logic [31:0]         rd_next;
    logic                unused_wdata;

    assign us_stb       = (pcnt == PW'(CLK_PER_US - 1));
    assign unused_wdata = ^bus.wdata[31:PERIOD_W];

    // free-running prescaler, wraps after CLK_PER_US cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
        end else if (us_stb) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    // per-channel write decode and irq enable vector
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            restart[i] = bus.wr_en &&
                         (bus.addr == ctrl_addr(i) ||
                          bus.addr == period_addr(i));
            irq_en[i]  = ctrl[i].irq_en;
        end
        clr = (bus.wr_en && bus.addr == A_STATUS) ?
              bus.wdata[NCH-1:0] : '0;
    end

    // CTRL/PERIOD registers; one-shot expiry drops en
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                ctrl[i] <= CTRL_DEF;
            end
            period[0] <= PERIOD_W'(DEF_P0);
            period[1] <= PERIOD_W'(DEF_P1);
            period[2] <= PERIOD_W'(DEF_P2);
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (bus.wr_en && bus.addr == ctrl_addr(i)) begin
                    ctrl[i] <= '{irq_en:   bus.wdata[CTRL_IRQ],
                                 periodic: bus.wdata[CTRL_PER],
                                 en:       bus.wdata[CTRL_EN]};
                end else if (expire[i] && !ctrl[i].periodic) begin
                    ctrl[i].en <= 1'b0;
                end
                if (bus.wr_en && bus.addr == period_addr(i)) begin
                    period[i] <= bus.wdata[PERIOD_W-1:0];
                end
            end
        end
    end

    // sticky expiry flags; a new set beats a same-cycle clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status <= '0;
        end else begin
            status <= (status & ~clr) | expire;
        end
    end

    // read mux for the registered read port
    always_comb begin
        rd_next = '0;
        unique case (bus.addr)
            A_CTRL0:  rd_next = 32'(ctrl[0]);
            A_PER0:   rd_next = 32'(period[0]);
            A_CTRL1:  rd_next = 32'(ctrl[1]);
            A_PER1:   rd_next = 32'(period[1]);
            A_CTRL2:  rd_next = 32'(ctrl[2]);
            A_PER2:   rd_next = 32'(period[2]);
            A_STATUS: rd_next = 32'(status);
            A_RSVD:   rd_next = '0;
        endcase
    end

    // read data, one cycle behind addr
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rdata <= '0;
        end else begin
            bus.rdata <= rd_next;
        end
    end

    assign irq_o = |(status & irq_en);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        tick_channel #(
            .PERIOD_W (PERIOD_W)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .us_stb  (us_stb),
            .en      (ctrl[i].en),
            .period  (period[i]),
            .restart (restart[i]),
            .tick    (tick_o[i]),
            .expire  (expire[i]),
            .level   (level_o[i])
        );
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: randomized scoreboard bench for tick_scheduler.
// A deadline-based model predicts ticks, levels, irq and read data.
module tb_tick_scheduler;
    import tick_pkg::*;

    localparam int CPU = 4;

    typedef struct {
        int         cyc;
        logic [2:0] v;
    } tick_ev_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       tick_o;
    logic [2:0]       level_o;
    logic             irq_o;

    tick_scheduler_if bus ();

    tick_scheduler #(
        .CLK_PER_US (CPU),
        .PERIOD_W   (20),
        .DEF_P0     (500),
        .DEF_P1     (2000),
        .DEF_P2     (1000000)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .tick_o  (tick_o),
        .level_o (level_o),
        .irq_o   (irq_o)
    );

    always #5 clk = ~clk;

    int          total;
    int          bad;
    int          cyc;
    tick_ev_t    exp_tick [$];
    logic [31:0] exp_rd [$];

    bit          m_en  [3];
    bit          m_pm  [3];
    bit          m_irq [3];
    int          m_per [3];
    int          m_dl  [3];
    logic [2:0]  m_lvl;
    logic [2:0]  m_st;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s cyc=%0d act=%0h exp=%0h",
                         nm, cyc, act, exp);
        end
    endtask

    function automatic int def_p(input int i);
        return (i == 0) ? 500 : (i == 1) ? 2000 : 1000000;
    endfunction

    // cycle of the P-th us strobe strictly after cycle c
    function automatic int deadline(input int c, input int p);
        int s;
        s = c - (c % CPU) + CPU - 1;
        if (s <= c) s += CPU;
        return s + CPU * (p - 1);
    endfunction

    function automatic logic [31:0] reg_val(input logic [2:0] a);
        int i;
        i = int'(a) >> 1;
        if (a == A_STATUS) return 32'(m_st);
        if (a == A_RSVD) return 32'd0;
        if (a[0]) return 32'(m_per[i]);
        return 32'({m_irq[i], m_pm[i], m_en[i]});
    endfunction

    task automatic model_init();
        for (int i = 0; i < 3; i++) begin
            m_en[i]  = 1'b1;
            m_pm[i]  = 1'b1;
            m_irq[i] = 1'b0;
            m_per[i] = def_p(i);
            m_dl[i]  = CPU * m_per[i] - 1;
        end
        m_lvl = '0;
        m_st  = '0;
        cyc   = 0;
        exp_rd.delete();
    endtask

    task automatic model_step();
        logic [2:0] tv;
        bit         hit;
        int         i;
        tick_ev_t   ev;
        exp_rd.push_back(reg_val(bus.addr));
        tv = '0;
        for (int k = 0; k < 3; k++) begin
            hit = bus.wr_en && (bus.addr == 3'(2 * k) ||
                                bus.addr == 3'(2 * k + 1));
            if (m_dl[k] == cyc && !hit) begin
                tv[k]    = 1'b1;
                m_lvl[k] = ~m_lvl[k];
                if (m_pm[k]) begin
                    m_dl[k] += CPU * m_per[k];
                end else begin
                    m_en[k] = 1'b0;
                    m_dl[k] = -1;
                end
            end
        end
        if (bus.wr_en && bus.addr == A_STATUS)
            m_st = m_st & ~bus.wdata[2:0];
        m_st = m_st | tv;
        if (bus.wr_en && bus.addr < A_STATUS) begin
            i = int'(bus.addr) >> 1;
            if (bus.addr[0]) begin
                m_per[i] = int'(bus.wdata[19:0]);
            end else begin
                m_en[i]  = bus.wdata[0];
                m_pm[i]  = bus.wdata[1];
                m_irq[i] = bus.wdata[2];
            end
            m_dl[i] = (m_en[i] && m_per[i] != 0) ?
                      deadline(cyc, m_per[i]) : -1;
        end
        if (tv != '0) begin
            ev.cyc = cyc + 1;
            ev.v   = tv;
            exp_tick.push_back(ev);
        end
        cyc++;
    endtask

    initial forever begin
        @(posedge clk);
        if (!reset) model_step();
    end

    // monitor: compares DUT outputs against the model each cycle
    initial forever begin
        tick_ev_t e;
        @(negedge clk);
        if (!reset) begin
            if (exp_rd.size() == 0)
                chk("rd_underflow", 32'(exp_rd.size()), 32'd1);
            else
                chk("rdata", bus.rdata, exp_rd.pop_front());
            chk("level", 32'(level_o), 32'(m_lvl));
            chk("irq", 32'(irq_o),
                32'(|(m_st & {m_irq[2], m_irq[1], m_irq[0]})));
            while (exp_tick.size() != 0 && exp_tick[0].cyc < cyc) begin
                chk("tick_missed", 32'(cyc), 32'(exp_tick[0].cyc));
                void'(exp_tick.pop_front());
            end
            if (tick_o != '0) begin
                if (exp_tick.size() == 0) begin
                    chk("tick_spurious", 32'(tick_o), 32'd0);
                end else begin
                    e = exp_tick.pop_front();
                    chk("tick_cyc", 32'(cyc), 32'(e.cyc));
                    chk("tick_vec", 32'(tick_o), 32'(e.v));
                end
            end
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.wr_en = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.wdata = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.wr_en = 1'b0;
            bus.addr  = 3'($urandom_range(0, 7));
        end
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.addr  = a;
        @(negedge clk);
        v = bus.rdata;
    endtask

    // leaves the caller at the negedge of ch's expiry cycle
    task automatic wait_expiry(input int ch, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (m_dl[ch] == cyc) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL expiry_wait ch=%0d act=timeout exp=expiry", ch);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tick"}, 32'(tick_o), 32'd0);
        chk({tag, "_level"}, 32'(level_o), 32'd0);
        chk({tag, "_irq"}, 32'(irq_o), 32'd0);
        chk({tag, "_rdata"}, bus.rdata, 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        bit          ok;
        int          n2;
        int          t0;
        int          t1;
        logic [2:0]  a;
        total     = 0;
        bad       = 0;
        cyc       = 0;
        reset     = 1'b0;
        bus.wr_en = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        #1 reset = 1'b1;
        #1 check_reset_outputs("por");
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        model_init();

        // default periods: ch0 every 2000 cycles, ch1 every 8000
        idle(16500);

        // PERIOD_0 = 3, periodic
        wr(A_PER0, 32'd3);
        wr(A_CTRL0, 32'h3);
        idle(60);

        // ch1 one-shot with irq, period 2
        wr(A_CTRL1, 32'h5);
        wr(A_PER1, 32'd2);
        idle(30);
        chk("oneshot_irq", 32'(irq_o), 32'd1);
        rd(A_CTRL1, v);
        chk("oneshot_ctrl1", v, 32'h4);
        rd(A_STATUS, v);
        chk("oneshot_status1", v & 32'h2, 32'h2);
        wr(A_STATUS, 32'h2);
        chk("irq_cleared", 32'(irq_o), 32'd0);

        // period 0 keeps ch2 silent
        wr(A_PER2, 32'd0);
        wr(A_CTRL2, 32'h1);
        n2 = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            bus.addr = 3'($urandom_range(0, 7));
            if (tick_o[2]) n2++;
        end
        chk("ch2_idle_ticks", 32'(n2), 32'd0);
        rd(A_STATUS, v);
        chk("ch2_status", v & 32'h4, 32'h0);

        // period write in ch0's expiry cycle suppresses the tick
        wait_expiry(0, ok);
        t0 = cyc;
        bus.wr_en = 1'b1;
        bus.addr  = A_PER0;
        bus.wdata = 32'd5;
        t1 = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            bus.wr_en = 1'b0;
            if (tick_o[0]) begin
                t1 = cyc;
                break;
            end
        end
        chk("collide_gap", 32'(t1 - (t0 + 1)), 32'd20);

        // STATUS clear in the same cycle as a new set: set wins
        wait_expiry(0, ok);
        bus.wr_en = 1'b1;
        bus.addr  = A_STATUS;
        bus.wdata = 32'h1;
        rd(A_STATUS, v);
        chk("w1c_vs_set", v & 32'h1, 32'h1);

        // randomized register traffic
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) begin
                a = 3'($urandom_range(0, 7));
                bus.wr_en = 1'b1;
                bus.addr  = a;
                if (a[0] && a < A_STATUS && $urandom_range(0, 7) != 0)
                    bus.wdata = 32'($urandom_range(0, 7));
                else
                    bus.wdata = $urandom;
            end else begin
                bus.wr_en = 1'b0;
                bus.addr  = 3'($urandom_range(0, 7));
            end
        end
        @(negedge clk);
        bus.wr_en = 1'b0;

        // asynchronous reset between clock edges, mid-count
        wr(A_PER0, 32'd3);
        wr(A_CTRL0, 32'h7);
        idle(37);
        #2 reset = 1'b1;
        #1 check_reset_outputs("async");
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        model_init();
        rd(A_PER2, v);
        chk("rst_per2", v, 32'd1000000);
        rd(A_CTRL0, v);
        chk("rst_ctrl0", v, 32'h3);
        rd(A_PER0, v);
        chk("rst_per0", v, 32'd500);
        idle(2100);

        idle(5);
        chk("tick_left", 32'(exp_tick.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        bad++;
        $display("FAIL watchdog act=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
